// File: rtl/pipelined_addsub.sv
// pipelined_addsub
// ----------------
// Wide adder/subtractor built as a chain of CHUNK-bit ripple segments, one
// segment per pipeline stage. The carry between segments is registered, so
// the critical path is one CHUNK-bit ripple regardless of N. Each operation
// takes S = N/CHUNK cycles, and the pipe accepts one operation per cycle.
// A global stall freezes every stage when the result at the tail is not
// taken.
//
// Parameters
//   N      operand/result width; must be a multiple of CHUNK
//   CHUNK  bits resolved per stage (S = N/CHUNK stages, latency S)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears valids and data)
//   in_valid   operands presented on inA/inB/sub
//   in_ready   pipe can take operands this cycle (= !stall)
//   sub        0: A+B, 1: A-B, sampled with the operands
//   inA, inB   N-bit operands
//   out_valid  result presented on sum/carry/overflow
//   out_ready  downstream takes the result this cycle
//   sum        result modulo 2^N
//   carry      carry out of bit N-1 (for subtract, 1 = no borrow)
//   overflow   two's-complement signed overflow

module pipelined_addsub #(
    parameter int N     = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sub,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         carry,
    output logic         overflow
);

    localparam int S = N / CHUNK;

    logic stall;

    // A result sitting at the tail that nobody takes freezes the whole pipe.
    // Bubbles are deliberately not squeezed out, which keeps the stall a
    // single global enable and in_ready independent of in_valid.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Stage k resolves result bits [k*CHUNK +: CHUNK]. Each stage only carries
    // the operand bits that are still unresolved (RW wide) and the result bits
    // already produced (DW wide), so the registers shrink/grow along the pipe.
    for (genvar k = 0; k < S; k++) begin : stg
        localparam int RW = N - k * CHUNK;
        localparam int DW = (k + 1) * CHUNK;

        logic [RW-1:0]    srcA;
        logic [RW-1:0]    srcB;
        logic             srcCarry;
        logic             srcValid;
        logic [CHUNK-1:0] chunkSum;
        logic             chunkCout;
        logic [DW-1:0]    nextSum;
        logic             regValid;
        logic             regCarry;
        logic [DW-1:0]    regSum;

        // The head stage works straight off the ports: subtraction becomes
        // A + ~B + 1 by inverting B and seeding the carry chain with sub.
        // Later stages take their inputs from the previous stage registers.
        if (k == 0) begin : head
            assign srcA     = inA;
            assign srcB     = inB ^ {N{sub}};
            assign srcCarry = sub;
            assign srcValid = in_valid;
            assign nextSum  = chunkSum;
        end else begin : body
            assign srcA     = stg[k-1].fwd.regA;
            assign srcB     = stg[k-1].fwd.regB;
            assign srcCarry = stg[k-1].regCarry;
            assign srcValid = stg[k-1].regValid;
            assign nextSum  = {chunkSum, stg[k-1].regSum};
        end

        // Plain ripple of full adders across the low CHUNK bits of what is
        // still unresolved; this is the only combinational carry path.
        for (genvar i = 0; i < CHUNK; i++) begin : bitCell
            logic cIn;
            logic cOut;

            if (i == 0) begin : first
                assign cIn = srcCarry;
            end else begin : chain
                assign cIn = bitCell[i-1].cOut;
            end

            assign chunkSum[i] = srcA[i] ^ srcB[i] ^ cIn;
            assign cOut        = (srcA[i] & srcB[i]) | (cIn & (srcA[i] ^ srcB[i]));
        end

        assign chunkCout = bitCell[CHUNK-1].cOut;

        // Valid moves on every unstalled edge so empty slots travel as zeros.
        // Data registers only load for real operations; their contents in an
        // empty slot are never looked at.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                regValid <= 1'b0;
                regCarry <= 1'b0;
                regSum   <= '0;
            end else if (!stall) begin
                regValid <= srcValid;
                if (srcValid) begin
                    regCarry <= chunkCout;
                    regSum   <= nextSum;
                end
            end
        end

        // Hand the still-unresolved upper operand bits to the next stage.
        // The final stage has nothing left to forward.
        if (k < S - 1) begin : fwd
            logic [RW-CHUNK-1:0] regA;
            logic [RW-CHUNK-1:0] regB;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    regA <= '0;
                    regB <= '0;
                end else if (!stall && srcValid) begin
                    regA <= srcA[RW-1:CHUNK];
                    regB <= srcB[RW-1:CHUNK];
                end
            end
        end

        // Signed overflow needs the carry into and out of the MSB, which only
        // both exist inside the final segment, so it is captured here.
        if (k == S - 1) begin : last
            logic regOvf;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    regOvf <= 1'b0;
                end else if (!stall && srcValid) begin
                    regOvf <= bitCell[CHUNK-1].cIn ^ chunkCout;
                end
            end
        end
    end

    assign out_valid = stg[S-1].regValid;
    assign sum       = stg[S-1].regSum;
    assign carry     = stg[S-1].regCarry;
    assign overflow  = stg[S-1].last.regOvf;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Testbench for pipelined_addsub. Three instances (CHUNK = 4, 16, 1) share
// the input stimulus; lane 0 (CHUNK=4) is the one the directed tests target.
// Inputs change just after a rising edge or on a falling edge; everything is
// sampled 1 time unit after a falling edge.

module tb_pipelined_addsub;

    localparam int N = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        sub;
    logic        out_ready;
    logic [15:0] inA;
    logic [15:0] inB;

    int  vectorsApplied = 0;
    int  miscompares    = 0;
    bit  randomOn       = 0;
    bit  collectOn      = 0;
    int  xfers          = 0;
    logic [15:0] gotQ[$];

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [17:0] exp;
    } vec_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic. Result packed as {overflow, carry, sum}.
    function automatic logic [17:0] refModel(input logic [15:0] a, input logic [15:0] b,
                                             input logic s);
        int          ua;
        int          ub;
        int          sa;
        int          sbv;
        int          r;
        logic [15:0] res;
        logic        c;
        logic        ov;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (!s) begin
            res = 16'(ua + ub);
            c   = (ua + ub) > 65535;
            r   = sa + sbv;
        end else begin
            res = 16'(ua - ub);
            c   = ua >= ub;
            r   = sa - sbv;
        end
        ov = (r > 32767) || (r < -32768);
        return {ov, c, res};
    endfunction

    function automatic vec_t mkVec(input string name, input logic [15:0] a, input logic [15:0] b,
                                   input logic s, input logic ov, input logic c,
                                   input logic [15:0] res);
        vec_t v;
        v.name = name;
        v.a    = a;
        v.b    = b;
        v.s    = s;
        v.exp  = {ov, c, res};
        return v;
    endfunction

    function automatic logic [15:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 16'hFFFF;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectorsApplied++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int CH = (g == 0) ? 4 : ((g == 1) ? 16 : 1);

        logic        inReady;
        logic        outValid;
        logic        resCarry;
        logic        resOvf;
        logic [15:0] resSum;
        logic [17:0] q[$];
        logic        prevStall;
        logic [17:0] prevOut;
        logic [17:0] expOut;

        pipelined_addsub #(.N(N), .CHUNK(CH)) dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (inReady),
            .sub      (sub),
            .inA      (inA),
            .inB      (inB),
            .out_valid(outValid),
            .out_ready(out_ready),
            .sum      (resSum),
            .carry    (resCarry),
            .overflow (resOvf)
        );

        // Random-phase scoreboard: push on accept, pop and compare on transfer.
        always @(negedge clk) begin
            #1;
            if (randomOn) begin
                checkOutput($sformatf("in_ready lane%0d", g), 32'(inReady),
                            32'(!(outValid && !out_ready)));
                if (prevStall) begin
                    checkOutput($sformatf("stall hold lane%0d", g),
                                32'({resOvf, resCarry, resSum}), 32'(prevOut));
                end
                if (outValid && out_ready) begin
                    if (q.size() == 0) begin
                        checkOutput($sformatf("unexpected result lane%0d", g), 32'd1, 32'd0);
                    end else begin
                        expOut = q.pop_front();
                        checkOutput($sformatf("result lane%0d", g),
                                    32'({resOvf, resCarry, resSum}), 32'(expOut));
                    end
                    if (g == 0) xfers++;
                end
                if (in_valid && inReady) q.push_back(refModel(inA, inB, sub));
                prevStall = outValid && !out_ready;
                prevOut   = {resOvf, resCarry, resSum};
            end else begin
                prevStall = 1'b0;
            end
        end
    end

    // Directed-phase collector of lane 0 transfers.
    always @(negedge clk) begin
        #1;
        if (collectOn && lane[0].outValid && out_ready) gotQ.push_back(lane[0].resSum);
    end

    // Present one operand pair right after a rising edge and hold it until
    // lane 0 takes it; returns just after the accepting edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic s,
                                 output bit ok);
        in_valid = 1'b1;
        inA      = a;
        inB      = b;
        sub      = s;
        ok       = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            #1;
            ok = lane[0].inReady;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic runVector(input vec_t v);
        bit ok;
        @(posedge clk);
        #1;
        applyStimulus(v.a, v.b, v.s, ok);
        checkOutput({v.name, " accept"}, 32'(ok), 32'd1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput({v.name, " early valid"}, 32'(lane[0].outValid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput({v.name, " valid"}, 32'(lane[0].outValid), 32'd1);
        checkOutput({v.name, " result"},
                    32'({lane[0].resOvf, lane[0].resCarry, lane[0].resSum}), 32'(v.exp));
    endtask

    initial begin
        vec_t vecs[10];
        bit   ok;
        int   stale;

        rst       = 1'b1;
        in_valid  = 1'b0;
        sub       = 1'b0;
        inA       = '0;
        inB       = '0;
        out_ready = 1'b1;

        vecs[0] = mkVec("add basic",    16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, 16'h2233);
        vecs[1] = mkVec("add carry all",16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000);
        vecs[2] = mkVec("add ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h8000);
        vecs[3] = mkVec("sub borrow",   16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, 16'hFFFE);
        vecs[4] = mkVec("sub ovf",      16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h7FFF);
        vecs[5] = mkVec("sub zero b",   16'h1357, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1357);
        vecs[6] = mkVec("add neg ovf",  16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1, 16'h0000);
        vecs[7] = mkVec("sub zeros",    16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000);
        vecs[8] = mkVec("sub pos ovf",  16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'h8000);
        vecs[9] = mkVec("add pattern",  16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 1'b0, 16'hFFFF);

        // Reset state of every lane
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset lane0", 32'({lane[0].outValid, lane[0].inReady, lane[0].resOvf,
                                        lane[0].resCarry, lane[0].resSum}), 32'h10000 << 2);
        checkOutput("reset lane1", 32'({lane[1].outValid, lane[1].inReady, lane[1].resOvf,
                                        lane[1].resCarry, lane[1].resSum}), 32'h10000 << 2);
        checkOutput("reset lane2", 32'({lane[2].outValid, lane[2].inReady, lane[2].resOvf,
                                        lane[2].resCarry, lane[2].resSum}), 32'h10000 << 2);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table of single operations with exact latency
        for (int i = 0; i < 10; i++) runVector(vecs[i]);

        // Back-pressure: 6 back-to-back ops, 3-cycle hold on the first result
        $display("[TB] back-pressure sequence");
        gotQ.delete();
        collectOn = 1'b1;
        @(posedge clk);
        #1;
        fork
            begin
                bit okS;
                for (int i = 1; i <= 6; i++) begin
                    applyStimulus(16'(i), 16'(i), 1'b0, okS);
                    checkOutput($sformatf("bp accept %0d", i), 32'(okS), 32'd1);
                end
            end
            begin
                bit found;
                found = 1'b0;
                for (int c = 0; c < 20 && !found; c++) begin
                    @(negedge clk);
                    found = lane[0].outValid;
                end
                checkOutput("bp first result seen", 32'(found), 32'd1);
                out_ready = 1'b0;
                #1;
                checkOutput("bp in_ready hold 1", 32'(lane[0].inReady), 32'd0);
                checkOutput("bp sum hold 1", 32'(lane[0].resSum), 32'd2);
                for (int h = 2; h <= 3; h++) begin
                    @(negedge clk);
                    #1;
                    checkOutput($sformatf("bp in_ready hold %0d", h), 32'(lane[0].inReady), 32'd0);
                    checkOutput($sformatf("bp sum hold %0d", h), 32'(lane[0].resSum), 32'd2);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        for (int c = 0; c < 40 && gotQ.size() < 6; c++) @(posedge clk);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2;
        collectOn = 1'b0;
        checkOutput("bp result count", 32'(gotQ.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < gotQ.size()) checkOutput($sformatf("bp result %0d", i), 32'(gotQ[i]), 32'(2 * (i + 1)));
            else checkOutput($sformatf("bp result %0d missing", i), 32'd0, 32'd1);
        end

        // Reset while three operations are in flight
        $display("[TB] reset mid-flight sequence");
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'(100 + i), 16'(i), 1'b0, ok);
            checkOutput($sformatf("rst accept %0d", i), 32'(ok), 32'd1);
        end
        rst = 1'b1;
        #1;
        checkOutput("rst out_valid", 32'(lane[0].outValid), 32'd0);
        checkOutput("rst in_ready", 32'(lane[0].inReady), 32'd1);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (lane[0].outValid) stale++;
        end
        checkOutput("rst no stale result", 32'(stale), 32'd0);
        runVector(mkVec("after reset", 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0, 16'h0030));

        // Random regression on all three lanes
        $display("[TB] random regression");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        randomOn = 1'b1;
        for (int c = 0; c < 40000 && xfers < 10000; c++) begin
            in_valid  = $urandom_range(0, 99) < 75;
            inA       = pickOperand();
            inB       = pickOperand();
            sub       = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 99) < 75;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        #2;
        randomOn = 1'b0;
        checkOutput("random transfer count", 32'(xfers >= 10000), 32'd1);
        checkOutput("drain lane0", 32'(lane[0].q.size()), 32'd0);
        checkOutput("drain lane1", 32'(lane[1].q.size()), 32'd0);
        checkOutput("drain lane2", 32'(lane[2].q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised successor to the team's generate-based ripple-carry adder.
- Splits an N-bit add/subtract into CHUNK-bit ripple segments, one segment per pipeline stage, with the carry registered between stages.
- Adds a valid/ready handshake, an add/sub mode and signed-overflow detection.
- Sits in datapaths that need wide adders at clock rates a full-width ripple cannot meet.

Parameters:
- N, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; S = N/CHUNK is the stage count and the latency.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands this cycle
- sub  input  1  0 = A+B, 1 = A-B; sampled with the operands
- inA  input  N  operand A
- inB  input  N  operand B
- out_valid  output  1  result presented
- out_ready  input  1  downstream accepts the result
- sum  output  N  result, modulo 2^N
- carry  output  1  carry out of bit N-1; for subtract, 1 = no borrow
- overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset: asynchronous assert, synchronous release. Clears all stage valid bits and all data registers. Outputs under reset: out_valid=0, sum=0, carry=0, overflow=0, in_ready=1.
- Accept condition: in_valid && in_ready. Output transfer condition: out_valid && out_ready.
- Subtract handling: at accept, B is XOR-inverted by sub, and the carry-in to stage 0 is set to sub.
- Stage k (0..S-1) computes bits [k*CHUNK +: CHUNK] from the registered A/B slices and the registered carry of stage k-1.
- Unresolved upper operand slices and the resolved lower sum slices travel down the pipe with each stage.
- Each stage holds a valid bit; data and valid advance together.
- Latency: a result accepted in cycle t appears in cycle t+S if there is no stall.
- Throughput: one operation per cycle.
- Stall: stall = out_valid && !out_ready. While stall=1:
  - all stages hold their contents;
  - in_ready=0;
  - sum, carry and overflow stay stable.
  - Bubbles are not compressed (global stall).
- in_ready = !stall. It is combinational from out_valid and out_ready; there is no combinational path from in_valid.
- Data from a cycle with in_valid=0 is don't-care, and its valid bit propagates as 0.
- carry = carry out of the final stage.
- overflow = carry into bit N-1 XOR carry out of bit N-1. It is computed in the final stage.
- sub=1 with inB=0: carry=1, sum=inA, overflow=0.
- S=1 (CHUNK=N): single-register adder with latency 1.
- Simultaneous accept and output transfer in the same cycle is legal; the pipe shifts by one.
- Reset mid-operation: all in-flight results are discarded, with no partial output. The first result after reset release is the first operand pair accepted after release.
- sum, carry and overflow are don't-care when out_valid=0. The bench checks them only on transfer.

Test Plan:
- Add, no stall. N=16, CHUNK=4. Drive inA=0x1234, inB=0x0FFF, sub=0, with out_ready=1 held. Required: exactly 4 cycles after accept, out_valid=1, sum=0x2233, carry=0, overflow=0.
- Carry across every stage boundary. Drive inA=0xFFFF, inB=0x0001, sub=0. Required: sum=0x0000, carry=1, overflow=0. Then drive inA=0x7FFF, inB=0x0001. Required: sum=0x8000, carry=0, overflow=1.
- Subtract. Drive inA=0x0005, inB=0x0007, sub=1. Required: sum=0xFFFE, carry=0 (borrow), overflow=0. Then drive inA=0x8000, inB=0x0001, sub=1. Required: sum=0x7FFF, carry=1, overflow=1.
- Back-pressure:
  - Stream 6 back-to-back operations i+i for i=1..6.
  - Hold out_ready=0 from the cycle the first result appears, for 3 cycles.
  - Required: in_ready=0 during the hold; sum=0x0002 stable throughout.
  - Required: after release, results 2,4,6,8,10,12 in order, with no loss or duplication.
- Reset mid-flight. Accept 3 operations, then assert rst for 1 cycle before any result emerges. Required: out_valid=0 immediately and no stale result afterwards. A new pair 0x0010+0x0020 yields 0x0030 after 4 cycles.
- Random regression, 10k operations with random valid/ready. Compare against a reference model (A±B mod 2^16, with carry and overflow). Also run with CHUNK=16 (S=1) and CHUNK=1 (S=16).
